// File: rtl/component_pkg.sv
// Shared sizing helpers for the component library: counter and pointer widths.
package component_pkg;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/component_updown_counter.sv
// Up/down counter with a parameterised reset value; simultaneous inc and dec hold.
module component_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= WIDTH'(RESET_VAL);
    end else if (inc && !dec) begin
      r_q <= r_q + 1'b1;
    end else if (dec && !inc) begin
      r_q <= r_q - 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/component_credit_fifo.sv
// Credit-managed FWFT FIFO behind a fixed-latency delay pipeline.
// Optional same-cycle pass-through when empty: COMPONENT_CREDIT_FIFO_BYPASS_EN.
module component_credit_fifo
  import component_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     launch_valid,
  output logic                     launch_ready,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow_err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic [CW-1:0]    w_credit;
  logic             w_full;
  logic             w_empty;
  logic             w_bypass;
  logic             w_pop;
  logic             w_pop_store;
  logic             w_push;
  logic             w_launch_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef COMPONENT_CREDIT_FIFO_BYPASS_EN
  assign w_bypass  = in_valid && w_empty;
  assign out_valid = !w_empty || w_bypass;
  assign out_data  = w_bypass ? in_data : r_mem[r_rd_ptr];
`else
  assign w_bypass  = 1'b0;
  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr];
`endif

  assign w_pop        = out_valid && out_ready;
  // A bypassed word that is consumed never touches storage or pointers.
  assign w_pop_store  = w_pop && !w_bypass;
  assign w_push       = in_valid && !(w_bypass && w_pop) && (!w_full || w_pop);
  assign w_launch_acc = launch_valid && launch_ready;

  component_updown_counter #(
    .WIDTH     (CW),
    .RESET_VAL (DEPTH)
  ) u_credit (
    .clk (clk),
    .rst (rst),
    .inc (w_pop),
    .dec (w_launch_acc),
    .q   (w_credit)
  );

  assign launch_ready = (w_credit != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push)      r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_store) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop_store})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign count        = r_count;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_component_credit_fifo.sv
// Scoreboard bench for component_credit_fifo (WIDTH=8, DEPTH=4).
module tb_component_credit_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef COMPONENT_CREDIT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             launch_valid;
  logic             launch_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       count;
  logic             overflow_err;

  always #5 clk = ~clk;

  component_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .overflow_err (overflow_err)
  );

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               m_credit = DEPTH;
  bit               m_ovf    = 1'b0;
  bit               s_valid;
  logic [WIDTH-1:0] s_data;
  bit               m_did_pop;
  logic [WIDTH-1:0] m_popped;

  // Samples outputs just before the edge, advances the reference model, then clocks.
  task automatic tick();
    bit byp, pop, acc;
    #1;
    s_valid   = out_valid;
    s_data    = out_data;
    m_did_pop = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_credit = DEPTH;
      m_ovf    = 1'b0;
    end else begin
      byp = BYP && in_valid && (exp_q.size() == 0);
      pop = out_ready && ((exp_q.size() != 0) || byp);
      acc = launch_valid && (m_credit != 0);
      if (pop && byp) begin
        m_did_pop = 1'b1;
        m_popped  = in_data;
      end else begin
        if (pop) begin
          m_did_pop = 1'b1;
          m_popped  = exp_q.pop_front();
        end
        if (in_valid) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(in_data);
          else                      m_ovf = 1'b1;
        end
      end
      m_credit = m_credit - int'(acc) + int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; launch_valid = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic fill4();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_word(WIDTH'(8'h11 * (k + 1)));
  endtask

  task automatic test_reset();
    rst = 1'b1; launch_valid = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (launch_ready !== 1'b1) $display("FAIL reset_launch_ready: got %b want 1", launch_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (overflow_err !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow_err); else n_pass++;
  endtask

  task automatic test_launch();
    launch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (launch_ready !== (i < 3)) $display("FAIL launch_ready_%0d: got %b want %b", i, launch_ready, (i < 3));
      else n_pass++;
    end
    tick();
    n_checks++; if (launch_ready !== 1'b0) $display("FAIL launch_5th: got %b want 0", launch_ready); else n_pass++;
    launch_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    fill4();
    n_checks++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) $display("FAIL fill_head: got %b/%h want 1/11", out_valid, out_data); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (!m_did_pop || s_valid !== 1'b1 || s_data !== m_popped) $display("FAIL drain_%0d: got %b/%h want 1/%h", i, s_valid, s_data, m_popped);
      else n_pass++;
    end
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL drain_empty: got %0d/%b want 0/0", count, out_valid); else n_pass++;
    n_checks++; if (launch_ready !== (m_credit != 0)) $display("FAIL drain_credit: got %b want %b", launch_ready, (m_credit != 0)); else n_pass++;
    // Credit back to exactly DEPTH: four launches succeed, then ready drops.
    launch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (launch_ready !== (i < 3)) $display("FAIL credit_return_%0d: got %b want %b", i, launch_ready, (i < 3));
      else n_pass++;
    end
    launch_valid = 1'b0;
  endtask

  task automatic test_full_pushpop();
    do_reset();
    fill4();
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (s_data !== 8'h11) $display("FAIL fullpp_out: got %h want 11", s_data); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL fullpp_count: got %0d want 4", count); else n_pass++;
    n_checks++; if (overflow_err !== 1'b0) $display("FAIL fullpp_ovf: got %b want 0", overflow_err); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== m_popped) $display("FAIL fullpp_drain_%0d: got %b/%h want 1/%h", i, s_valid, s_data, m_popped);
      else n_pass++;
    end
    out_ready = 1'b0;
    n_checks++; if (s_data !== 8'h55) $display("FAIL fullpp_last: got %h want 55", s_data); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    fill4();
    in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_err); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL ovf_count: got %0d want 4", count); else n_pass++;
    repeat (10) tick();
    n_checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_err); else n_pass++;
    n_checks++; if (out_data !== 8'h11) $display("FAIL ovf_head: got %h want 11", out_data); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== m_popped) $display("FAIL ovf_drain_%0d: got %b/%h want 1/%h", i, s_valid, s_data, m_popped);
      else n_pass++;
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_dropped: got %b want 0", out_valid); else n_pass++;
    do_reset();
    n_checks++; if (overflow_err !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow_err); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) push_word(WIDTH'(r * 16 + k + 1));
      n_checks++;
      if (count !== 3'(exp_q.size())) $display("FAIL wrap_count_%0d: got %0d want %0d", r, count, exp_q.size());
      else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== m_popped) $display("FAIL wrap_pop_%0d_%0d: got %b/%h want 1/%h", r, k, s_valid, s_data, m_popped);
        else n_pass++;
      end
      while (exp_q.size() > 1) begin
        tick();
        n_checks++;
        if (s_data !== m_popped) $display("FAIL wrap_trim_%0d: got %h want %h", r, s_data, m_popped);
        else n_pass++;
      end
      out_ready = 1'b0;
    end
    push_word(8'hA1);
    push_word(8'hA2);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA3;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL midrst_state: got %0d/%b want 0/0", count, out_valid); else n_pass++;
    n_checks++; if (launch_ready !== 1'b1) $display("FAIL midrst_credit: got %b want 1", launch_ready); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    if (BYP) begin
      n_checks++; if (s_valid !== 1'b1 || s_data !== 8'h77) $display("FAIL bypass_same: got %b/%h want 1/77", s_valid, s_data); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL bypass_count: got %0d want 0", count); else n_pass++;
    end else begin
      n_checks++; if (s_valid !== 1'b0) $display("FAIL nobypass_same: got %b want 0", s_valid); else n_pass++;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h77 || count !== 3'd1) $display("FAIL nobypass_next: got %b/%h/%0d want 1/77/1", out_valid, out_data, count); else n_pass++;
      tick();
      n_checks++; if (s_data !== m_popped || count !== 3'd0) $display("FAIL nobypass_pop: got %h/%0d want %h/0", s_data, count, m_popped); else n_pass++;
    end
    out_ready = 1'b0;
    n_checks++; if (launch_ready !== (m_credit != 0)) $display("FAIL bypass_credit: got %b want %b", launch_ready, (m_credit != 0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_fill_drain();
    test_full_pushpop();
    test_overflow();
    test_wrap();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/component_credit_fifo.md
COMPONENT_CREDIT_FIFO -- requirements
Module: component_credit_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries and initial credit count; legal range 1..256, any value (not restricted to powers of two).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port launch_valid  input  1: upstream requests to issue one word into the fixed-latency delay pipeline.
REQ-006 SHALL have port launch_ready  output  1: a credit is available; a launch is accepted when launch_valid && launch_ready.
REQ-007 SHALL have port in_valid  input  1: a word arrives from the delay pipeline output this cycle; no backpressure.
REQ-008 SHALL have port in_data  input  WIDTH: arriving word.
REQ-009 SHALL have port out_valid  output  1: head word present.
REQ-010 SHALL have port out_data  output  WIDTH: head word, first-word-fall-through.
REQ-011 SHALL have port out_ready  input  1: consumer accepts; pop = out_valid && out_ready.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1): words currently stored.
REQ-013 SHALL have port overflow_err  output  1: sticky protocol-error flag.

Function
REQ-014 SHALL hold a credit counter, width $clog2(DEPTH+1); launch_ready = (credit != 0).
REQ-015 SHALL update credit_next = credit - launch_accepted + pop; simultaneous launch and pop leave credit unchanged.
REQ-016 SHALL maintain the invariant credit + in-flight words + count == DEPTH for a compliant upstream.
REQ-017 SHALL write in_data at wr_ptr when in_valid && (count < DEPTH || pop); wr_ptr then increments, wrapping DEPTH-1 -> 0.
REQ-018 SHALL drive out_data = mem[rd_ptr] combinationally and out_valid = (count != 0), except as modified by REQ-026.
REQ-019 SHALL increment rd_ptr on pop, wrapping DEPTH-1 -> 0.
REQ-020 SHALL update count by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-021 SHALL accept push and pop in the same cycle when full; the read of the head slot precedes the edge-time write into it.
REQ-022 SHALL, on in_valid while count == DEPTH without pop, drop the word, leave pointers and count unchanged, and set overflow_err (held until reset).
REQ-023 SHALL ignore out_ready while out_valid is 0; no pop, no credit return.
REQ-024 SHALL have an input-to-output latency of one cycle: a word pushed on edge N is visible on out_data after edge N.

Reset
REQ-025 SHALL on rst: credit = DEPTH; count = 0; wr_ptr = rd_ptr = 0; overflow_err = 0; out_valid = 0; launch_ready = 1 after the reset edge. Storage contents are not reset. Reset mid-operation discards all stored and in-flight words; the upstream delay pipeline is reset on the same rst.

Configuration
REQ-026 SHALL, with COMPONENT_CREDIT_FIFO_BYPASS_EN defined, pass a word straight through when count == 0 && in_valid: out_valid = 1 and out_data = in_data in the same cycle. If out_ready is also 1, this is a pop (credit returned) and nothing is written; otherwise the word is written normally.
REQ-027 SHALL, without COMPONENT_CREDIT_FIFO_BYPASS_EN, have no combinational in->out path; REQ-024 latency applies in all cases.

Structure
REQ-028 SHALL import the pointer/count width helper (function returning $clog2 of n+1) from shared package component_pkg.
REQ-029 SHALL instantiate sub-module component_updown_counter (parameters WIDTH, RESET_VAL; inputs inc, dec) for the credit counter; the FIFO store is implemented inline.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset, then 4 launches back-to-back -> launch_ready falls after the 4th edge; a 5th launch_valid is not accepted; credit stays 0.
REQ-031 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, out_data=0x11; then out_ready=1 for 4 cycles -> outputs 0x11..0x44 in order, credit returns to 4.
REQ-032 Full FIFO, in_valid=1 (0x55) with pop -> 0x11 out, count stays 4, 0x55 becomes the last entry; no overflow_err.
REQ-033 Full FIFO, in_valid=1 (0x66), out_ready=0 -> 0x66 dropped, overflow_err=1 and still 1 after 10 idle cycles; cleared only by rst.
REQ-034 Fill 3 entries and drain 2, repeated 6 times -> pointers wrap correctly with no lost or reordered word; reset asserted mid-stream -> count=0, credit=4, out_valid=0 on the next cycle.
REQ-035 Bypass build, empty FIFO, in_valid=1 0x77, out_ready=1 -> out_valid=1, out_data=0x77 in the same cycle, count stays 0; in a non-bypass build -> 0x77 appears one cycle later.
